// File: rtl/game_event_scheduler.sv
// Score keeper and animation sequencer between the ball/paddle logic and the
// LED animation block.
//   CLOCK, RESET        : system clock, synchronous active-high reset
//   anim_tick           : one-cycle strobe where the animation block samples
//   goal_in_1/2         : one-cycle goal pulses from the play logic
//   new_game            : one-cycle pulse, clears scores/flags/queue
//   score_1/2           : per-player scores
//   goal_player_1/2,
//   win_player_1/2      : one-hot animation request levels
//   play_enable         : ball motion allowed
//   game_over           : a win occurred, waiting for new_game
//   queue_overflow      : sticky, an event was dropped on a full queue
module game_event_scheduler #(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ANIM_TICKS  = 28,
  parameter int unsigned GAP_TICKS   = 2
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               anim_tick,
  input  logic               goal_in_1,
  input  logic               goal_in_2,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               goal_player_1,
  output logic               goal_player_2,
  output logic               win_player_1,
  output logic               win_player_2,
  output logic               play_enable,
  output logic               game_over,
  output logic               queue_overflow
);

  localparam int unsigned PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned QCNT_W   = PTR_W + 1;
  localparam int unsigned TICK_MAX = (ANIM_TICKS > GAP_TICKS) ? ANIM_TICKS : GAP_TICKS;
  localparam int unsigned TICK_W   = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;

  localparam logic [1:0] EV_GOAL_1 = 2'd0;
  localparam logic [1:0] EV_GOAL_2 = 2'd1;
  localparam logic [1:0] EV_WIN_1  = 2'd2;
  localparam logic [1:0] EV_WIN_2  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, PLAY, GAP} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0]  score_1_q, score_1_d;
  logic [SCORE_W-1:0]  score_2_q, score_2_d;
  logic                game_over_q, game_over_d;
  logic                overflow_q, overflow_d;
  logic                play_enable_q, play_enable_d;
  logic [3:0]          req_q, req_d;
  logic [1:0]          mem_q [QUEUE_DEPTH];
  logic [1:0]          mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0]   count_q, count_d;

  logic                accept;
  logic                push;
  logic                pop;
  logic                full;
  logic [1:0]          push_ev;

  // Scoring, event queue and animation sequencing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_1_d     = score_1_q;
    score_2_d     = score_2_q;
    game_over_d   = game_over_q;
    overflow_d    = overflow_q;
    req_d         = req_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    push_ev       = EV_GOAL_1;
    push          = 1'b0;
    pop           = 1'b0;
    full          = (count_q == QCNT_W'(QUEUE_DEPTH));
    accept        = play_enable_q && !game_over_q && !new_game && (goal_in_1 || goal_in_2);

    // Player 1 wins a simultaneous goal; player 2's pulse is discarded.
    if (accept) begin
      if (goal_in_1) begin
        score_1_d = SCORE_W'(score_1_q + 1'b1);
        if (score_1_d == SCORE_W'(WIN_SCORE)) begin
          push_ev     = EV_WIN_1;
          game_over_d = 1'b1;
        end else begin
          push_ev = EV_GOAL_1;
        end
      end else begin
        score_2_d = SCORE_W'(score_2_q + 1'b1);
        if (score_2_d == SCORE_W'(WIN_SCORE)) begin
          push_ev     = EV_WIN_2;
          game_over_d = 1'b1;
        end else begin
          push_ev = EV_GOAL_2;
        end
      end
    end

    // A running animation cannot be aborted, so new_game only cancels ISSUE.
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !new_game) begin
          pop                   = 1'b1;
          req_d                 = '0;
          req_d[mem_q[rd_ptr_q]] = 1'b1;
          state_d               = ISSUE;
        end
      end
      ISSUE: begin
        if (new_game) begin
          req_d   = '0;
          state_d = IDLE;
        end else if (anim_tick) begin
          req_d   = '0;
          cnt_d   = TICK_W'(ANIM_TICKS - 1);
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (anim_tick) begin
          if (cnt_q == '0) begin
            if (GAP_TICKS == 0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = TICK_W'(GAP_TICKS - 1);
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (anim_tick) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle pop frees the slot a push into a full queue needs.
    push = accept && (!full || pop);
    if (accept && !push) overflow_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = push_ev;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (new_game) begin
      score_1_d   = '0;
      score_2_d   = '0;
      game_over_d = 1'b0;
      overflow_d  = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end

    play_enable_d = (state_d == IDLE) && (count_d == '0) && !game_over_d;
  end

  // State registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      score_1_q     <= '0;
      score_2_q     <= '0;
      game_over_q   <= 1'b0;
      overflow_q    <= 1'b0;
      play_enable_q <= 1'b0;
      req_q         <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_1_q     <= score_1_d;
      score_2_q     <= score_2_d;
      game_over_q   <= game_over_d;
      overflow_q    <= overflow_d;
      play_enable_q <= play_enable_d;
      req_q         <= req_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign score_1        = score_1_q;
  assign score_2        = score_2_q;
  assign goal_player_1  = req_q[EV_GOAL_1];
  assign goal_player_2  = req_q[EV_GOAL_2];
  assign win_player_1   = req_q[EV_WIN_1];
  assign win_player_2   = req_q[EV_WIN_2];
  assign play_enable    = play_enable_q;
  assign game_over      = game_over_q;
  assign queue_overflow = overflow_q;

endmodule

// File: tb/tb_game_event_scheduler.sv
// Bench for game_event_scheduler: an event-queue model checks the default
// instance every cycle; a shallow-queue instance covers overflow handling.
module tb_game_event_scheduler;

  localparam int WIN   = 5;
  localparam int ANIM  = 28;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic       RESET, anim_tick, goal_in_1, goal_in_2, new_game;
  logic [3:0] a_s1, a_s2;
  logic       a_gp1, a_gp2, a_wp1, a_wp2, a_pe, a_go, a_ovf;

  logic       b_tick, b_g1, b_g2, b_ng;
  logic [3:0] b_s1, b_s2;
  logic       b_gp1, b_gp2, b_wp1, b_wp2, b_pe, b_go, b_ovf;

  game_event_scheduler dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .anim_tick(anim_tick),
    .goal_in_1(goal_in_1), .goal_in_2(goal_in_2), .new_game(new_game),
    .score_1(a_s1), .score_2(a_s2),
    .goal_player_1(a_gp1), .goal_player_2(a_gp2),
    .win_player_1(a_wp1), .win_player_2(a_wp2),
    .play_enable(a_pe), .game_over(a_go), .queue_overflow(a_ovf)
  );

  game_event_scheduler #(.QUEUE_DEPTH(2), .ANIM_TICKS(100)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .anim_tick(b_tick),
    .goal_in_1(b_g1), .goal_in_2(b_g2), .new_game(b_ng),
    .score_1(b_s1), .score_2(b_s2),
    .goal_player_1(b_gp1), .goal_player_2(b_gp2),
    .win_player_1(b_wp1), .win_player_2(b_wp2),
    .play_enable(b_pe), .game_over(b_go), .queue_overflow(b_ovf)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: pending events in a queue, a request waiting for its tick, and a
  // single budget of animation+gap ticks that must elapse before the next one.
  int  m_s1, m_s2, m_req, m_left, m_code;
  bit  m_over, m_ovf, m_pe, m_wait, m_accept;
  int  mq[$];

  always @(posedge CLOCK) begin : model
    if (RESET) begin
      m_s1 = 0; m_s2 = 0; m_req = -1; m_left = 0;
      m_over = 0; m_ovf = 0; m_pe = 0; m_wait = 0;
      mq.delete();
    end else begin
      m_accept = m_pe && !m_over && !new_game && (goal_in_1 || goal_in_2);
      if (m_wait) begin
        if (new_game) begin
          m_wait = 0; m_req = -1;
        end else if (anim_tick) begin
          m_wait = 0; m_req = -1; m_left = ANIM + GAP;
        end
      end else if (m_left > 0) begin
        if (anim_tick) m_left--;
      end else if (mq.size() > 0 && !new_game) begin
        m_req  = mq.pop_front();
        m_wait = 1;
      end
      if (m_accept) begin
        if (goal_in_1) begin
          m_s1++;
          m_code = (m_s1 == WIN) ? 2 : 0;
          if (m_s1 == WIN) m_over = 1;
        end else begin
          m_s2++;
          m_code = (m_s2 == WIN) ? 3 : 1;
          if (m_s2 == WIN) m_over = 1;
        end
        if (mq.size() < DEPTH) mq.push_back(m_code);
        else m_ovf = 1;
      end
      if (new_game) begin
        m_s1 = 0; m_s2 = 0; m_over = 0; m_ovf = 0;
        mq.delete();
      end
      m_pe = !m_wait && (m_left == 0) && (mq.size() == 0) && !m_over;
    end
  end

  bit cmp_en = 0;
  logic [14:0] act_v, exp_v;

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      act_v = {a_s1, a_s2, a_gp1, a_gp2, a_wp1, a_wp2, a_pe, a_go, a_ovf};
      exp_v = {4'(m_s1), 4'(m_s2), m_req == 0, m_req == 1, m_req == 2, m_req == 3,
               m_pe, m_over, m_ovf};
      checks++;
      if (act_v === exp_v) passed++;
      else $display("FAIL model_cycle t=%0t: got %h, expected %h", $time, act_v, exp_v);
    end
  end

  // Request rising-edge counters for the default instance.
  int rise_gp1 = 0, rise_gp2 = 0, rise_wp2 = 0;
  logic p_gp1 = 0, p_gp2 = 0, p_wp2 = 0;
  always @(negedge CLOCK) begin
    if (a_gp1 === 1'b1 && !p_gp1) rise_gp1++;
    if (a_gp2 === 1'b1 && !p_gp2) rise_gp2++;
    if (a_wp2 === 1'b1 && !p_wp2) rise_wp2++;
    p_gp1 <= (a_gp1 === 1'b1);
    p_gp2 <= (a_gp2 === 1'b1);
    p_wp2 <= (a_wp2 === 1'b1);
  end

  task automatic step(input bit g1, input bit g2, input bit ng, input bit tk);
    @(negedge CLOCK);
    goal_in_1 = g1; goal_in_2 = g2; new_game = ng; anim_tick = tk;
  endtask

  task automatic stepb(input bit g1, input bit ng);
    @(negedge CLOCK);
    b_g1 = g1; b_ng = ng;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic wait_pe(input int budget);
    int i;
    i = 0;
    while (a_pe !== 1'b1 && i < budget) begin
      ticks(1);
      i++;
    end
    if (a_pe !== 1'b1) chk("wait_play_enable_timeout", 0, 1);
  endtask

  int r1, r2, rw;
  int seen;

  initial begin
    RESET = 1; anim_tick = 0; goal_in_1 = 0; goal_in_2 = 0; new_game = 0;
    b_tick = 0; b_g1 = 0; b_g2 = 0; b_ng = 0;
    step(0, 0, 0, 0);
    cmp_en = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_score_1", a_s1, 0);
    chk("rst_play_enable", a_pe, 0);
    chk("rst_game_over", a_go, 0);
    chk("rst_goal_player_1", a_gp1, 0);
    chk("rst_b_overflow", b_ovf, 0);
    RESET = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("idle_play_enable", a_pe, 1);

    // Single goal: request until the trigger tick, then 28+2 ticks.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("goal1_score", a_s1, 1);
    chk("goal1_pe_low", a_pe, 0);
    step(0, 0, 0, 0);
    chk("goal1_req_high", a_gp1, 1);
    step(0, 0, 0, 0);
    chk("goal1_req_held", a_gp1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("goal1_req_dropped", a_gp1, 0);
    ticks(29);
    chk("goal1_pe_before_last_tick", a_pe, 0);
    ticks(1);
    chk("goal1_pe_after_30_ticks", a_pe, 1);

    // Simultaneous goals: only player 1 counts.
    step(0, 0, 1, 0);
    r1 = rise_gp1; r2 = rise_gp2;
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("both_score_1", a_s1, 1);
    chk("both_score_2", a_s2, 0);
    wait_pe(100);
    chk("both_goal1_anims", rise_gp1 - r1, 1);
    chk("both_goal2_anims", rise_gp2 - r2, 0);

    // Player 2 reaches the winning score.
    step(0, 0, 1, 0);
    r2 = rise_gp2; rw = rise_wp2;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      wait_pe(100);
    end
    chk("p2_goal_anims", rise_gp2 - r2, 4);
    chk("p2_score_4", a_s2, 4);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("p2_win_score", a_s2, 5);
    chk("p2_game_over", a_go, 1);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      if (a_wp2 === 1'b1) seen = 1;
      else step(0, 0, 0, 0);
    end
    chk("p2_win_request", seen, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("blocked_goal_score_1", a_s1, 0);
    ticks(40);
    chk("game_over_pe_low", a_pe, 0);
    chk("win_anims", rise_wp2 - rw, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("new_game_pe", a_pe, 1);
    chk("new_game_score_2", a_s2, 0);
    chk("new_game_over", a_go, 0);

    // Goal while an event is pending is ignored.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pending_goal_score", a_s1, 1);
    chk("pending_no_overflow", a_ovf, 0);
    wait_pe(100);

    // new_game while the request is waiting for its tick.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("issue_req_high", a_gp2, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("issue_ng_req_low", a_gp2, 0);
    chk("issue_ng_score_1", a_s1, 0);
    chk("issue_ng_pe", a_pe, 1);

    // new_game mid-animation: countdown still completes.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    ticks(5);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("play_ng_score_1", a_s1, 0);
    chk("play_ng_pe_low", a_pe, 0);
    ticks(24);
    chk("play_ng_pe_still_low", a_pe, 0);
    ticks(1);
    chk("play_ng_pe_restored", a_pe, 1);

    // Shallow queue: back-to-back goals with gating held open.
    force dut_b.play_enable_q = 1'b1;
    stepb(1, 0);
    stepb(1, 0);
    stepb(1, 0);
    stepb(0, 0);
    chk("b_full_no_overflow", b_ovf, 0);
    stepb(1, 0);
    stepb(0, 0);
    chk("b_overflow_set", b_ovf, 1);
    chk("b_score_1", b_s1, 4);
    chk("b_req_held", b_gp1, 1);
    stepb(0, 1);
    stepb(0, 0);
    chk("b_overflow_cleared", b_ovf, 0);
    chk("b_score_cleared", b_s1, 0);
    chk("b_req_dropped", b_gp1, 0);
    release dut_b.play_enable_q;
    stepb(0, 0);
    stepb(0, 0);
    chk("b_pe_after_release", b_pe, 1);

    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
